sram_responder: RTL

SRAM_RESPONDER -- requirements
Module: sram_responder

---
 rtl/sram_responder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sram_responder.sv
// sram_responder
//   Single-port SRAM-style slave: word memory plus a small config space.
//   Config space is selected when sram_addr[31:16] == CONF_BASE:
//     0x0000  LED register   (write lanes 0-1, read {16'b0, led})
//     0x0004  timer          (free-running, present only with SRAM_RESP_TIMER_EN)
//     0x0008  switch inputs  (read-only, sampled in the request cycle)
//     others  read 0, writes dropped
//   Read data is registered: it appears one cycle after the request and
//   holds until the next read.
//
//   Optional build macro: SRAM_RESP_TIMER_EN (builds the timer at 0x0004).
//
// Ports
//   clk         clock, rising edge
//   resetn      asynchronous active-low reset
//   sram_en     request valid
//   sram_wen    byte write enables (0 = read)
//   sram_addr   byte address, [1:0] ignored
//   sram_wdata  write data
//   sram_rdata  registered read data
//   switch      external switch levels
//   led         LED register contents
module sram_responder #(
  parameter int          ADDR_W    = 10,
  parameter logic [15:0] CONF_BASE = 16'hBFAF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       r_mem [0:DEPTH-1];
  logic [31:0]       r_rdata;
  logic [15:0]       r_led;

  logic              w_conf;
  logic              w_rd;
  logic              w_wr;
  logic [15:0]       w_off;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_timer_val;
  logic [31:0]       w_conf_rdata;

  assign w_conf = (sram_addr[31:16] == CONF_BASE);
  assign w_rd   = sram_en && (sram_wen == 4'b0000);
  assign w_wr   = sram_en && (sram_wen != 4'b0000);
  assign w_off  = sram_addr[15:0];
  // Upper non-config address bits are simply dropped, so memory aliases.
  assign w_idx  = sram_addr[ADDR_W+1:2];

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr && !w_conf) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_wen[i]) r_mem[w_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_led <= 16'h0;
    end else if (w_wr && w_conf && (w_off == 16'h0000)) begin
      if (sram_wen[0]) r_led[7:0]  <= sram_wdata[7:0];
      if (sram_wen[1]) r_led[15:8] <= sram_wdata[15:8];
    end
  end

`ifdef SRAM_RESP_TIMER_EN
  logic [31:0] r_timer;

  // A write takes priority over the increment; unwritten lanes keep their
  // current (non-incremented) value for that one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_timer <= 32'h0;
    end else if (w_wr && w_conf && (w_off == 16'h0004)) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_wen[i]) r_timer[8*i +: 8] <= sram_wdata[8*i +: 8];
      end
    end else begin
      r_timer <= r_timer + 32'd1;
    end
  end

  assign w_timer_val = r_timer;
`else
  assign w_timer_val = 32'h0;
`endif

  always_comb begin
    w_conf_rdata = 32'h0;
    case (w_off)
      16'h0000: w_conf_rdata = {16'h0, r_led};
      16'h0004: w_conf_rdata = w_timer_val;
      16'h0008: w_conf_rdata = {24'h0, switch};
      default:  w_conf_rdata = 32'h0;
    endcase
  end

  // Memory has already absorbed a write from the previous edge, so a read
  // right after a write naturally sees the merged word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata <= 32'h0;
    end else if (w_rd) begin
      r_rdata <= w_conf ? w_conf_rdata : r_mem[w_idx];
    end
  end

  assign sram_rdata = r_rdata;
  assign led        = r_led;

endmodule
